oper_mode_ctrl: RTL and testbench

//  Sequences the inversion datapath's operating mode. Button presses edit a pending mode.
//  The pending mode is committed only at a frame boundary (VS rising edge), so a mode change never tears mid-frame.
//  A video-timing lock monitor forces DIRECT bypass while input timing is unstable or absent.

---
 rtl/oper_mode_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_oper_mode_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oper_mode_ctrl.sv
// Operating-mode sequencer: buttons edit a pending mode that is committed on VS rise,
// and a video-timing lock monitor forces DIRECT while input timing is unstable or absent.
module oper_mode_ctrl #(
    parameter int H_WIDTH       = 1920,
    parameter int V_HEIGHT      = 1080,
    parameter int LOCK_FRAMES   = 4,
    parameter int UNLOCK_FRAMES = 2,
    parameter int FRAME_TIMEOUT = 4000000
) (
    input  logic       vin_clk_i,
    input  logic       rst_n,
    input  logic       vs_i,
    input  logic       de_i,
    input  logic       btn_cycle_i,
    input  logic       btn_inv_i,
    input  logic       btn_bypass_i,
    output logic [2:0] mode_o,
    output logic       locked_o,
    output logic [3:0] led_o
);
    localparam int LW = $clog2(LOCK_FRAMES + 1);
    localparam int UW = $clog2(UNLOCK_FRAMES + 1);
    localparam int WW = $clog2(FRAME_TIMEOUT + 1);

    localparam logic [11:0]   H_W      = 12'(H_WIDTH);
    localparam logic [11:0]   V_H      = 12'(V_HEIGHT);
    localparam logic [LW-1:0] LOCK_N   = LW'(LOCK_FRAMES);
    localparam logic [UW-1:0] UNLOCK_N = UW'(UNLOCK_FRAMES);
    localparam logic [WW-1:0] WD_MAX   = WW'(FRAME_TIMEOUT);
    localparam logic [WW-1:0] WD_LAST  = WW'(FRAME_TIMEOUT - 1);

    localparam logic [2:0] MODE_DIRECT   = 3'd0;
    localparam logic [2:0] MODE_BLK_DARK = 3'd2;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ACQUIRE,
        ST_LOCKED,
        ST_HOLD
    } lock_state_t;

    lock_state_t     state, state_next;
    logic [LW-1:0]   acq_cnt, acq_next;
    logic [UW-1:0]   miss_cnt, miss_next;

    logic            vs_r, de_r;
    logic [11:0]     pix_cnt, lin_cnt, lin_inc, lin_eff;
    logic            line_err, seen_vs;
    logic [WW-1:0]   wd_cnt;
    logic            vs_rise, de_rise, de_fall, line_bad, frame_good, wd_expire, locked;
    logic [2:0]      pending, pending_next, active;

    assign vs_rise    = vs_i & ~vs_r;
    assign de_rise    = de_i & ~de_r;
    assign de_fall    = ~de_i & de_r;
    assign line_bad   = de_fall & (pix_cnt != H_W);
    assign lin_inc    = (lin_cnt == 12'hFFF) ? lin_cnt : lin_cnt + 12'd1;
    // A line ending on the VS-rise cycle still belongs to the frame being judged.
    assign lin_eff    = de_fall ? lin_inc : lin_cnt;
    assign frame_good = seen_vs & ~line_err & ~line_bad & (lin_eff == V_H);
    assign wd_expire  = (wd_cnt == WD_LAST);
    assign locked     = (state == ST_LOCKED) || (state == ST_HOLD);

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vs_r     <= 1'b0;
            de_r     <= 1'b0;
            pix_cnt  <= '0;
            lin_cnt  <= '0;
            line_err <= 1'b0;
            seen_vs  <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            vs_r <= vs_i;
            de_r <= de_i;
            if (de_rise)
                pix_cnt <= 12'd1;
            else if (de_i && pix_cnt != 12'hFFF)
                pix_cnt <= pix_cnt + 12'd1;
            if (vs_rise) begin
                lin_cnt  <= '0;
                line_err <= 1'b0;
                seen_vs  <= 1'b1;
            end else begin
                if (de_fall)
                    lin_cnt <= lin_inc;
                if (line_bad)
                    line_err <= 1'b1;
            end
            if (wd_expire)
                seen_vs <= 1'b0;
            if (vs_rise)
                wd_cnt <= '0;
            else if (wd_cnt != WD_MAX)
                wd_cnt <= wd_cnt + WW'(1);
        end
    end

    always_comb begin
        state_next = state;
        acq_next   = acq_cnt;
        miss_next  = miss_cnt;
        if (vs_rise) begin
            unique case (state)
                ST_UNLOCKED: if (frame_good) begin
                    acq_next   = LW'(1);
                    state_next = (LOCK_FRAMES == 1) ? ST_LOCKED : ST_ACQUIRE;
                end
                ST_ACQUIRE: if (frame_good) begin
                    acq_next = acq_cnt + LW'(1);
                    if (acq_next == LOCK_N)
                        state_next = ST_LOCKED;
                end else begin
                    acq_next   = '0;
                    state_next = ST_UNLOCKED;
                end
                ST_LOCKED: if (!frame_good) begin
                    miss_next  = UW'(1);
                    state_next = (UNLOCK_FRAMES == 1) ? ST_UNLOCKED : ST_HOLD;
                end
                ST_HOLD: if (frame_good) begin
                    miss_next  = '0;
                    state_next = ST_LOCKED;
                end else begin
                    miss_next = miss_cnt + UW'(1);
                    if (miss_next == UNLOCK_N)
                        state_next = ST_UNLOCKED;
                end
                default: state_next = ST_UNLOCKED;
            endcase
        end
        // Loss of VS entirely outranks whatever the frame verdict said.
        if (wd_expire) begin
            state_next = ST_UNLOCKED;
            acq_next   = '0;
            miss_next  = '0;
        end
    end

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_UNLOCKED;
            acq_cnt  <= '0;
            miss_cnt <= '0;
            locked_o <= 1'b0;
        end else begin
            state    <= state_next;
            acq_cnt  <= acq_next;
            miss_cnt <= miss_next;
            locked_o <= (state_next == ST_LOCKED) || (state_next == ST_HOLD);
        end
    end

    always_comb begin
        pending_next = pending;
        if (btn_cycle_i)
            pending_next = {pending[2:1] + 2'd1, pending[0]};
        else if (btn_inv_i)
            pending_next = {pending[2:1], ~pending[0]};
    end

    function automatic logic [3:0] led_of(input logic [2:0] m);
        return {m[0], m[2:1] == 2'd3, m[2:1] == 2'd2, m[2:1] == 2'd1};
    endfunction

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pending <= MODE_BLK_DARK;
            active  <= MODE_BLK_DARK;
            mode_o  <= MODE_DIRECT;
            led_o   <= 4'b0001;
        end else begin
            pending <= pending_next;
            if (vs_rise)
                active <= pending;
            mode_o <= (btn_bypass_i || !locked) ? MODE_DIRECT : active;
            led_o  <= led_of(pending_next);
        end
    end
endmodule

// File: tb/tb_oper_mode_ctrl.sv
// Bench for oper_mode_ctrl: directed scenarios plus a randomized frame phase, all
// compared every cycle against a frame-level behavioural model of mode and lock rules.
module tb_oper_mode_ctrl;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int LK = 2;
    localparam int UL = 2;
    localparam int TO = 300;

    logic       vin_clk_i = 1'b0;
    logic       rst_n, vs_i, de_i, btn_cycle_i, btn_inv_i, btn_bypass_i;
    logic [2:0] mode_o;
    logic       locked_o;
    logic [3:0] led_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bit m_prev_vs, m_prev_de, m_seen, m_locked, m_bad;
    int m_pix, m_lines, m_since_vs, m_streak, m_pending, m_active;
    logic [2:0] exp_mode;
    logic       exp_locked;
    logic [3:0] exp_led;
    logic [3:0] led_tab [8] = '{4'd0, 4'd8, 4'd1, 4'd9, 4'd2, 4'd10, 4'd4, 4'd12};

    oper_mode_ctrl #(
        .H_WIDTH(H), .V_HEIGHT(V), .LOCK_FRAMES(LK), .UNLOCK_FRAMES(UL), .FRAME_TIMEOUT(TO)
    ) dut (
        .vin_clk_i(vin_clk_i), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i),
        .btn_cycle_i(btn_cycle_i), .btn_inv_i(btn_inv_i), .btn_bypass_i(btn_bypass_i),
        .mode_o(mode_o), .locked_o(locked_o), .led_o(led_o)
    );

    always #5 vin_clk_i = ~vin_clk_i;

    initial begin
        #2000000;
        $display("[TB] FAIL time_limit: simulation ran past its bound");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_prev_vs = 0; m_prev_de = 0; m_seen = 0; m_locked = 0; m_bad = 0;
        m_pix = 0; m_lines = 0; m_since_vs = 0; m_streak = 0;
        m_pending = 2; m_active = 2;
        exp_mode = 3'd0; exp_locked = 1'b0; exp_led = 4'b0001;
    endtask

    // Lock as streaks: enough good frames in a row to lock, enough bad in a row to unlock.
    task automatic judge(input bit good);
        if (!m_locked) begin
            if (good) begin
                m_streak++;
                if (m_streak >= LK) begin m_locked = 1; m_streak = 0; end
            end else m_streak = 0;
        end else begin
            if (!good) begin
                m_streak++;
                if (m_streak >= UL) begin m_locked = 0; m_streak = 0; end
            end else m_streak = 0;
        end
    endtask

    task automatic model_edge();
        bit vs_rise, de_rise, de_fall, expire, bad;
        int lines;
        vs_rise  = vs_i && !m_prev_vs;
        de_rise  = de_i && !m_prev_de;
        de_fall  = !de_i && m_prev_de;
        exp_mode = (btn_bypass_i || !m_locked) ? 3'd0 : 3'(m_active);
        lines = m_lines;
        bad   = m_bad;
        if (de_fall) begin
            if (lines < 4095) lines++;
            if (m_pix != H) bad = 1;
        end
        if (de_rise) m_pix = 1;
        else if (de_i && m_pix < 4095) m_pix++;
        expire = (m_since_vs == TO - 1);
        if (m_since_vs < TO) m_since_vs++;
        if (vs_rise) begin
            judge(m_seen && !bad && lines == V);
            m_active = m_pending;
            lines = 0; bad = 0; m_seen = 1; m_since_vs = 0;
        end
        if (expire) begin m_locked = 0; m_streak = 0; m_seen = 0; end
        if (btn_cycle_i) m_pending = (m_pending + 2) % 8;
        else if (btn_inv_i) m_pending = m_pending ^ 1;
        m_lines = lines; m_bad = bad;
        m_prev_vs = vs_i; m_prev_de = de_i;
        exp_locked = m_locked;
        exp_led    = led_tab[m_pending];
    endtask

    task automatic checkOutput();
        check_val("mode_o", {1'b0, mode_o}, {1'b0, exp_mode});
        check_val("locked_o", {3'b0, locked_o}, {3'b0, exp_locked});
        check_val("led_o", led_o, exp_led);
    endtask

    task automatic applyStimulus(input bit vs, input bit de, input bit cyc, input bit inv);
        vs_i = vs; de_i = de; btn_cycle_i = cyc; btn_inv_i = inv;
        @(posedge vin_clk_i);
        model_edge();
        #1;
        checkOutput();
    endtask

    // One frame: VS pulse, blanking, then V lines of H pixels (one line may be short).
    task automatic send_frame(input int short_line, input int press_at, input logic [1:0] kind);
        int c = 0;
        bit p;
        for (int i = 0; i < 5; i++) begin
            p = (c == press_at);
            applyStimulus(i < 2, 0, p && kind[0], p && kind[1]);
            c++;
        end
        for (int l = 0; l < V; l++) begin
            for (int x = 0; x < H + 3; x++) begin
                p = (c == press_at);
                applyStimulus(0, x < ((l == short_line) ? H - 1 : H), p && kind[0], p && kind[1]);
                c++;
            end
        end
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        int s, pa, st;
        logic [1:0] k;
        rst_n = 0; vs_i = 0; de_i = 0; btn_cycle_i = 0; btn_inv_i = 0; btn_bypass_i = 0;
        model_reset();
        repeat (2) @(posedge vin_clk_i);
        #1;
        checkOutput();
        check_val("rst_led", led_o, 4'b0001);
        @(negedge vin_clk_i) rst_n = 1;

        $display("[TB] lock acquisition");
        send_frame(-1, -1, 2'b00);
        check_val("acq_f1", {3'b0, locked_o}, 4'd0);
        send_frame(-1, -1, 2'b00);
        check_val("acq_f2", {3'b0, locked_o}, 4'd0);
        send_frame(-1, -1, 2'b00);
        check_val("acq_f3", {3'b0, locked_o}, 4'd1);
        check_val("acq_mode", {1'b0, mode_o}, 4'd2);

        $display("[TB] button edits and frame commit");
        send_frame(-1, 20, 2'b01);
        check_val("cyc_led", led_o, 4'b0010);
        check_val("cyc_hold_mode", {1'b0, mode_o}, 4'd2);
        send_frame(-1, -1, 2'b00);
        check_val("cyc_commit", {1'b0, mode_o}, 4'd4);
        send_frame(-1, 20, 2'b11);
        check_val("both_led", led_o, 4'b0100);
        send_frame(-1, -1, 2'b00);
        check_val("both_commit", {1'b0, mode_o}, 4'd6);

        $display("[TB] bypass");
        btn_bypass_i = 1;
        applyStimulus(0, 0, 0, 0);
        check_val("byp_on", {1'b0, mode_o}, 4'd0);
        stall(3);
        btn_bypass_i = 0;
        applyStimulus(0, 0, 0, 0);
        check_val("byp_off", {1'b0, mode_o}, 4'd6);

        $display("[TB] bad lines, hold and unlock");
        send_frame(1, -1, 2'b00);
        send_frame(2, -1, 2'b00);
        check_val("hold_locked", {3'b0, locked_o}, 4'd1);
        send_frame(-1, -1, 2'b00);
        check_val("unl_locked", {3'b0, locked_o}, 4'd0);
        check_val("unl_mode", {1'b0, mode_o}, 4'd0);
        send_frame(-1, -1, 2'b00);
        send_frame(-1, -1, 2'b00);
        check_val("relock", {3'b0, locked_o}, 4'd1);
        send_frame(0, -1, 2'b00);
        send_frame(-1, -1, 2'b00);
        check_val("hold2", {3'b0, locked_o}, 4'd1);
        send_frame(3, -1, 2'b00);
        send_frame(-1, -1, 2'b00);
        check_val("hold_recovered", {3'b0, locked_o}, 4'd1);
        send_frame(-1, -1, 2'b00);

        $display("[TB] VS watchdog");
        stall(320);
        check_val("wd_locked", {3'b0, locked_o}, 4'd0);
        check_val("wd_mode", {1'b0, mode_o}, 4'd0);
        send_frame(-1, -1, 2'b00);
        send_frame(-1, -1, 2'b00);
        check_val("wd_relock_early", {3'b0, locked_o}, 4'd0);
        send_frame(-1, -1, 2'b00);
        check_val("wd_relock", {3'b0, locked_o}, 4'd1);

        $display("[TB] reset mid-line");
        send_frame(-1, 10, 2'b10);
        send_frame(-1, -1, 2'b00);
        check_val("m7_mode", {1'b0, mode_o}, 4'd7);
        for (int i = 0; i < 5; i++) applyStimulus(i < 2, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);
        #2 rst_n = 0;
        #1;
        check_val("arst_mode", {1'b0, mode_o}, 4'd0);
        check_val("arst_locked", {3'b0, locked_o}, 4'd0);
        check_val("arst_led", led_o, 4'b0001);
        model_reset();
        vs_i = 0; de_i = 0;
        repeat (3) @(posedge vin_clk_i);
        @(negedge vin_clk_i) rst_n = 1;
        applyStimulus(0, 0, 0, 0);
        check_val("post_rst_led", led_o, 4'b0001);
        send_frame(-1, -1, 2'b00);
        send_frame(-1, -1, 2'b00);
        send_frame(-1, -1, 2'b00);
        check_val("post_rst_mode", {1'b0, mode_o}, 4'd2);

        $display("[TB] randomized frames");
        for (int f = 0; f < 20; f++) begin
            s  = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1;
            pa = int'($urandom_range(48));
            k  = 2'($urandom_range(3));
            btn_bypass_i = ($urandom_range(4) == 0);
            send_frame(s, pa, k);
            if ($urandom_range(5) == 0) begin
                st = int'($urandom_range(300, 200));
                stall(st);
            end
        end
        btn_bypass_i = 0;
        send_frame(-1, -1, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
